// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one AXI read port between the icache and dcache
// refill paths. Each refill is a single 8-beat INCR burst. Ties are broken
// round-robin. The line is gathered into a shared buffer, and the winner
// then receives a one-cycle grant.
module refill_arbiter (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_rd_req,
    input  logic [31:0]      ic_addr,
    output logic             ic_gnt,
    input  logic             dc_rd_req,
    input  logic [31:0]      dc_addr,
    output logic             dc_gnt,
    output logic [7:0][31:0] line_data,
    output logic [3:0]       arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t     state, state_nxt;
    logic       last;      // id of the requester served most recently (1 = dcache)
    logic [2:0] cnt;       // beat index into the line buffer, wraps modulo 8
    logic       win_dc;
    logic       unused_addr_bits;

    // Line-offset bits of the miss addresses are dropped: bursts are line aligned
    assign unused_addr_bits = ^{ic_addr[4:0], dc_addr[4:0]};

    // Winner select: a lone requester wins; on a tie the one not served last wins
    assign win_dc = dc_rd_req & (~ic_rd_req | ~last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ic_rd_req || dc_rd_req) state_nxt = S_AR;
            S_AR:   if (arready)                state_nxt = S_R;
            S_R:    if (rvalid && rlast)        state_nxt = S_DONE;
            S_DONE:                             state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register and the latched winner id
    always_comb begin
        arvalid = (state == S_AR);
        rready  = (state == S_R);
        ic_gnt  = (state == S_DONE) && (arid == 4'd0);
        dc_gnt  = (state == S_DONE) && (arid == 4'd1);
        arlen   = 8'd7;
        arsize  = 3'b010;
        arburst = 2'b01;
    end

    // Datapath: latch the winner, count beats, fill the line, update round-robin
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            araddr    <= '0;
            arid      <= '0;
            cnt       <= '0;
            line_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ic_rd_req || dc_rd_req) begin
                        arid   <= {3'b000, win_dc};
                        araddr <= win_dc ? {dc_addr[31:5], 5'b0} : {ic_addr[31:5], 5'b0};
                    end
                end
                S_AR: begin
                    if (arready) cnt <= '0;
                end
                S_R: begin
                    if (rvalid) begin
                        line_data[cnt] <= rdata;
                        cnt            <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    last <= arid[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: table of refills plus hand sequences
// for the data-hold and reset-mid-burst corners.
module tb_refill_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             ic_rd_req, dc_rd_req;
    logic [31:0]      ic_addr, dc_addr;
    logic             ic_gnt, dc_gnt;
    logic [7:0][31:0] line_data;
    logic [3:0]       arid;
    logic [31:0]      araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid, arready;
    logic [31:0]      rdata;
    logic             rlast, rvalid, rready;

    refill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .dc_rd_req(dc_rd_req), .dc_addr(dc_addr), .dc_gnt(dc_gnt),
        .line_data(line_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ic_req;
        logic        dc_req;
        logic [31:0] ic_a;
        logic [31:0] dc_a;
        int          ar_stall;
        int          r_gap;
        int          rlast_k;
        logic [31:0] base;
        logic [3:0]  exp_id;
        logic [31:0] exp_addr;
        int          exp_gnt_lat;
        logic        drop;
    } vec_t;

    vec_t             vt[6];
    logic [7:0][31:0] exp_line;
    int               cyc   = 0;
    int               total = 0;
    int               bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Acts as the AXI slave for one refill, starting from an IDLE cycle with
    // the requests already driven; ends one cycle after the grant.
    task automatic serve(input logic [3:0] eid, input logic [31:0] eaddr,
                         input int stall, input int gap, input int lk,
                         input logic [31:0] base, input logic drop,
                         output int ar_lat, output int gnt_lat);
        int t0;
        int n;
        t0 = cyc;
        n  = 0;
        chk("hold_idle", line_data, exp_line);
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        ar_lat = cyc - t0;
        chk("arvalid_seen", arvalid, 1'b1);
        chk("araddr", araddr, eaddr);
        chk("arid", arid, eid);
        chk("arlen", arlen, 8'd7);
        chk("hold_ar", line_data, exp_line);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("ar_stable", {arvalid, arid, araddr}, {1'b1, eid, eaddr});
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rready", rready, 1'b1);
        for (int k = 0; k <= lk; k++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_nognt", {ic_gnt, dc_gnt}, 2'b00);
                chk("gap_hold", line_data, exp_line);
            end
            rvalid = 1'b1;
            rdata  = base + 32'(k);
            rlast  = (k == lk);
            tick();
            exp_line[k] = base + 32'(k);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rdata  = '0;
        end
        gnt_lat = cyc - t0;
        chk("ic_gnt", ic_gnt, eid == 4'd0);
        chk("dc_gnt", dc_gnt, eid == 4'd1);
        chk("line", line_data, exp_line);
        if (drop) begin
            ic_rd_req = 1'b0;
            dc_rd_req = 1'b0;
        end
        tick();
        chk("gnt_pulse", {ic_gnt, dc_gnt}, 2'b00);
        chk("line_after", line_data, exp_line);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int al, gl, n;
        //           ic   dc   ic_a          dc_a          stl gap lk  base     id    addr          lat drop
        vt[0] = '{1'b1, 1'b0, 32'h1FC0_0044, 32'h0,        0, 0, 7, 32'h100, 4'd0, 32'h1FC0_0040, 10, 1'b1};
        vt[1] = '{1'b0, 1'b1, 32'h0,         32'h8000_101F, 5, 2, 7, 32'h200, 4'd1, 32'h8000_1000, 31, 1'b1};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0040, 0, 0, 4, 32'h300, 4'd0, 32'h0000_0020, 7,  1'b0};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0040, 0, 0, 7, 32'h400, 4'd1, 32'h0000_0040, 10, 1'b0};
        vt[4] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0040, 0, 0, 7, 32'h500, 4'd0, 32'h0000_0020, 10, 1'b0};
        vt[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0040, 0, 0, 7, 32'h600, 4'd1, 32'h0000_0040, 10, 1'b1};

        rst = 1'b1;
        ic_rd_req = 1'b0; dc_rd_req = 1'b0;
        ic_addr = '0; dc_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        exp_line = '0;
        tick();
        tick();
        chk("rst_out", {ic_gnt, dc_gnt, arvalid, rready, arid, araddr}, '0);
        chk("rst_line", line_data, '0);
        chk("const", {arlen, arsize, arburst}, {8'd7, 3'b010, 2'b01});
        rst = 1'b0;

        // Table: single refills, stalls, early rlast, alternating ties
        for (int i = 0; i < 6; i++) begin
            ic_rd_req = vt[i].ic_req;
            dc_rd_req = vt[i].dc_req;
            ic_addr   = vt[i].ic_a;
            dc_addr   = vt[i].dc_a;
            serve(vt[i].exp_id, vt[i].exp_addr, vt[i].ar_stall, vt[i].r_gap,
                  vt[i].rlast_k, vt[i].base, vt[i].drop, al, gl);
            chk("ar_lat", al, 1);
            chk("gnt_lat", gl, vt[i].exp_gnt_lat);
        end

        // Data hold: icache request arrives the cycle after the dcache grant
        ic_rd_req = 1'b1;
        ic_addr   = 32'h0000_3FE4;
        serve(4'd0, 32'h0000_3FE0, 0, 2, 7, 32'h700, 1'b1, al, gl);
        chk("hold_gnt_lat", gl, 26);

        // Reset in the middle of a burst, then both requesters contend afresh
        ic_rd_req = 1'b1; dc_rd_req = 1'b1;
        ic_addr = 32'h0000_1000; dc_addr = 32'h0000_2000;
        n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        chk("mid_arvalid", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1;
            rdata  = 32'hA00 + 32'(k);
            tick();
        end
        rvalid = 1'b0;
        rdata  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_line = '0;
        chk("mid_rst_axi", {arvalid, rready, ic_gnt, dc_gnt}, 4'b0000);
        chk("mid_rst_line", line_data, exp_line);
        serve(4'd0, 32'h0000_1000, 0, 0, 7, 32'h900, 1'b0, al, gl);
        chk("post_rst_lat", gl, 10);
        serve(4'd1, 32'h0000_2000, 0, 0, 7, 32'hB00, 1'b1, al, gl);
        chk("post_rst_lat2", gl, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
